// File: rtl/serial_to_parallel_packer.sv
// Packs a stream of WIDTH-bit beats into BUFFER_SIZE-element frames on a valid/ready output.
// Fill bank plus output bank; a frame appears one cycle after its final beat unless the output bank is busy.
module serial_to_parallel_packer #(
    parameter int WIDTH       = 8,
    parameter int BUFFER_SIZE = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [WIDTH-1:0]                      data_in,
    input  logic                                  data_in_valid,
    input  logic                                  data_in_last,
    output logic                                  data_in_ready,
    output logic [BUFFER_SIZE-1:0][WIDTH-1:0]     data_out,
    output logic [$clog2(BUFFER_SIZE+1)-1:0]      data_out_count,
    output logic                                  data_out_valid,
    input  logic                                  data_out_ready
);

    localparam int IW = $clog2(BUFFER_SIZE);
    localparam int CW = $clog2(BUFFER_SIZE + 1);

    typedef enum logic {FILL, HOLD} state_e;

    state_e                             state_q, state_d;
    logic [IW-1:0]                      idx_q, idx_d;
    logic [BUFFER_SIZE-1:0][WIDTH-1:0]  fill_q, fill_d;
    logic [BUFFER_SIZE-1:0][WIDTH-1:0]  out_q, out_d;
    logic [CW-1:0]                      hold_cnt_q, hold_cnt_d;
    logic [CW-1:0]                      out_cnt_q, out_cnt_d;
    logic                               out_vld_q, out_vld_d;
    logic                               in_rdy_q, in_rdy_d;

    logic                               accept;
    logic                               complete;
    logic                               out_free;
    logic                               out_take;
    logic [BUFFER_SIZE-1:0][WIDTH-1:0]  frame;
    logic [CW-1:0]                      frame_cnt;

    always_comb begin
        accept    = data_in_valid && in_rdy_q;
        complete  = accept && (data_in_last || (idx_q == IW'(BUFFER_SIZE - 1)));
        out_take  = out_vld_q && data_out_ready;
        out_free  = !out_vld_q || data_out_ready;
        // The fill bank is all-zero beyond idx, so an early close is already padded.
        frame        = fill_q;
        frame[idx_q] = data_in;
        frame_cnt    = CW'(idx_q) + CW'(1);

        state_d    = state_q;
        idx_d      = idx_q;
        fill_d     = fill_q;
        out_d      = out_q;
        hold_cnt_d = hold_cnt_q;
        out_cnt_d  = out_cnt_q;
        out_vld_d  = out_vld_q && !data_out_ready;

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (complete) begin
                        idx_d = '0;
                        if (out_free) begin
                            out_d     = frame;
                            out_cnt_d = frame_cnt;
                            out_vld_d = 1'b1;
                            fill_d    = '0;
                        end else begin
                            fill_d     = frame;
                            hold_cnt_d = frame_cnt;
                            state_d    = HOLD;
                        end
                    end else begin
                        fill_d = frame;
                        idx_d  = idx_q + IW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_take) begin
                    out_d     = fill_q;
                    out_cnt_d = hold_cnt_q;
                    out_vld_d = 1'b1;
                    fill_d    = '0;
                    idx_d     = '0;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        // Registered so data_in_ready never depends combinationally on data_out_ready.
        in_rdy_d = (state_d == FILL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            idx_q      <= '0;
            fill_q     <= '0;
            out_q      <= '0;
            hold_cnt_q <= '0;
            out_cnt_q  <= '0;
            out_vld_q  <= 1'b0;
            in_rdy_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            fill_q     <= fill_d;
            out_q      <= out_d;
            hold_cnt_q <= hold_cnt_d;
            out_cnt_q  <= out_cnt_d;
            out_vld_q  <= out_vld_d;
            in_rdy_q   <= in_rdy_d;
        end
    end

    assign data_in_ready  = in_rdy_q;
    assign data_out       = out_q;
    assign data_out_count = out_cnt_q;
    assign data_out_valid = out_vld_q;

endmodule

// File: tb/tb_serial_to_parallel_packer.sv
// Bench for serial_to_parallel_packer: directed scenarios plus random traffic against a frame-queue model.
module tb_serial_to_parallel_packer;

    localparam int W  = 8;
    localparam int BS = 16;
    localparam int CW = $clog2(BS + 1);

    logic                    clk = 1'b0;
    logic                    rst;
    logic [W-1:0]            data_in;
    logic                    data_in_valid;
    logic                    data_in_last;
    logic                    data_in_ready;
    logic [BS-1:0][W-1:0]    data_out;
    logic [CW-1:0]           data_out_count;
    logic                    data_out_valid;
    logic                    data_out_ready;

    serial_to_parallel_packer #(.WIDTH(W), .BUFFER_SIZE(BS)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_last   (data_in_last),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_count (data_out_count),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: accepted beats gather into a list; a closed list becomes a zero-padded frame.
    logic [W-1:0]         beats[$];
    logic [BS-1:0][W-1:0] exp_dat_q[$];
    int                   exp_cnt_q[$];
    int                   frames_out = 0;
    logic                 prev_hold = 1'b0;
    logic [BS-1:0][W-1:0] prev_dat;
    logic [CW-1:0]        prev_cnt;
    logic [BS-1:0][W-1:0] mon_fr;
    int                   mon_cnt;

    always @(negedge clk) begin
        if (rst) begin
            beats.delete();
            exp_dat_q.delete();
            exp_cnt_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                total++;
                if (data_out_valid !== 1'b1 || data_out !== prev_dat || data_out_count !== prev_cnt) begin
                    bad++;
                    $display("FAIL stable_under_backpressure: valid=%b cnt=%0d dat=%h required valid=1 cnt=%0d dat=%h",
                             data_out_valid, data_out_count, data_out, prev_cnt, prev_dat);
                end
            end
            if (data_out_valid && data_out_ready) begin
                total++;
                if (exp_dat_q.size() == 0) begin
                    bad++;
                    $display("FAIL frame_unexpected: got cnt=%0d dat=%h required no frame", data_out_count, data_out);
                end else begin
                    mon_fr  = exp_dat_q.pop_front();
                    mon_cnt = exp_cnt_q.pop_front();
                    frames_out++;
                    if (data_out !== mon_fr || int'(data_out_count) != mon_cnt) begin
                        bad++;
                        $display("FAIL frame_content: got cnt=%0d dat=%h required cnt=%0d dat=%h",
                                 data_out_count, data_out, mon_cnt, mon_fr);
                    end
                end
            end
            prev_hold = data_out_valid && !data_out_ready;
            prev_dat  = data_out;
            prev_cnt  = data_out_count;
            if (data_in_valid && data_in_ready) begin
                beats.push_back(data_in);
                if (data_in_last || beats.size() == BS) begin
                    mon_fr = '0;
                    foreach (beats[i]) mon_fr[i] = beats[i];
                    exp_dat_q.push_back(mon_fr);
                    exp_cnt_q.push_back(beats.size());
                    beats.delete();
                end
            end
        end
    end

    // Called and returns at posedge+1; the beat is accepted on the last edge waited for.
    task automatic send_beat(input logic [W-1:0] d, input logic l, output int waits);
        waits         = 0;
        data_in       = d;
        data_in_last  = l;
        data_in_valid = 1'b1;
        @(negedge clk);
        while (!data_in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!data_in_ready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: ready=%b required 1 within 200 cycles", data_in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int w;
        logic [W-1:0] first;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total += 4;
        if (data_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", data_out_valid); end
        if (data_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b required 1", data_in_ready); end
        if (data_out_count !== '0) begin bad++; $display("FAIL reset_count: got %0d required 0", data_out_count); end
        if (data_out !== '0) begin bad++; $display("FAIL reset_data: got %h required 0", data_out); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        data_out_ready = 1'b0;
        for (int i = 0; i < BS + 5; i++) send_beat(W'($urandom), 1'b0, w);
        data_in_valid = 1'b0;
        total++;
        if (data_out_valid !== 1'b1) begin bad++; $display("FAIL prereset_valid: got %b required 1", data_out_valid); end
        rst = 1'b1;
        #1;
        total += 4;
        if (data_out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid: got %b required 0", data_out_valid); end
        if (data_in_ready !== 1'b1) begin bad++; $display("FAIL async_reset_in_ready: got %b required 1", data_in_ready); end
        if (data_out_count !== '0) begin bad++; $display("FAIL async_reset_count: got %0d required 0", data_out_count); end
        if (data_out !== '0) begin bad++; $display("FAIL async_reset_data: got %h required 0", data_out); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        data_out_ready = 1'b1;
        first = W'($urandom);
        send_beat(first, 1'b0, w);
        for (int i = 1; i < BS; i++) send_beat(W'($urandom), 1'b0, w);
        data_in_valid = 1'b0;
        total++;
        if (data_out_valid !== 1'b1 || data_out[0] !== first) begin
            bad++;
            $display("FAIL post_reset_first_elem: valid=%b elem0=%h required valid=1 elem0=%h", data_out_valid, data_out[0], first);
        end
        idle(2);
    endtask

    task automatic test_full_frame();
        int w;
        logic [BS-1:0][W-1:0] exp;
        data_out_ready = 1'b1;
        for (int i = 0; i < BS; i++) begin
            exp[i] = W'(i);
            send_beat(W'(i), 1'b0, w);
            if (i == BS - 2) begin
                total++;
                if (data_out_valid !== 1'b0) begin bad++; $display("FAIL full_early_valid: got %b required 0", data_out_valid); end
            end
        end
        data_in_valid = 1'b0;
        total += 3;
        if (data_out_valid !== 1'b1) begin bad++; $display("FAIL full_latency: valid=%b required 1", data_out_valid); end
        if (data_out_count !== CW'(BS)) begin bad++; $display("FAIL full_count: got %0d required %0d", data_out_count, BS); end
        if (data_out !== exp) begin bad++; $display("FAIL full_data: got %h required %h", data_out, exp); end
        @(posedge clk);
        #1;
        total++;
        if (data_out_valid !== 1'b0) begin bad++; $display("FAIL full_valid_one_cycle: got %b required 0", data_out_valid); end
        idle(1);
    endtask

    task automatic test_early_last();
        int w;
        logic [BS-1:0][W-1:0] exp;
        exp = '0;
        exp[0] = 8'hA1;
        exp[1] = 8'hA2;
        exp[2] = 8'hA3;
        data_out_ready = 1'b1;
        send_beat(8'hA1, 1'b0, w);
        send_beat(8'hA2, 1'b0, w);
        send_beat(8'hA3, 1'b1, w);
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
        total += 3;
        if (data_out_valid !== 1'b1) begin bad++; $display("FAIL early_valid: got %b required 1", data_out_valid); end
        if (data_out_count !== CW'(3)) begin bad++; $display("FAIL early_count: got %0d required 3", data_out_count); end
        if (data_out !== exp) begin bad++; $display("FAIL early_data: got %h required %h", data_out, exp); end
        idle(2);
    endtask

    task automatic test_backpressure();
        int w;
        logic [BS-1:0][W-1:0] f1, f2;
        data_out_ready = 1'b0;
        for (int i = 0; i < 2 * BS; i++) send_beat(W'($urandom), 1'b0, w);
        data_in_valid = 1'b0;
        total++;
        if (exp_dat_q.size() != 2) begin
            bad++;
            $display("FAIL bp_model_frames: got %0d required 2", exp_dat_q.size());
        end else begin
            f1 = exp_dat_q[0];
            f2 = exp_dat_q[1];
            total += 3;
            if (data_in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready: got %b required 0", data_in_ready); end
            if (data_out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b required 1", data_out_valid); end
            if (data_out !== f1) begin bad++; $display("FAIL bp_first_frame: got %h required %h", data_out, f1); end
            idle(3);
            total++;
            if (data_in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_persist: got %b required 0", data_in_ready); end
            data_out_ready = 1'b1;
            @(posedge clk);
            #1;
            total += 3;
            if (data_out_valid !== 1'b1) begin bad++; $display("FAIL bp_second_valid: got %b required 1", data_out_valid); end
            if (data_out !== f2) begin bad++; $display("FAIL bp_second_frame: got %h required %h", data_out, f2); end
            if (data_in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b required 1", data_in_ready); end
            @(posedge clk);
            #1;
            total++;
            if (data_out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b required 0", data_out_valid); end
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int w;
        int totw;
        int f0;
        totw = 0;
        f0   = frames_out;
        data_out_ready = 1'b1;
        for (int i = 0; i < 4 * BS; i++) begin
            send_beat(W'($urandom), 1'b0, w);
            totw += w;
        end
        data_in_valid = 1'b0;
        total++;
        if (totw != 0) begin bad++; $display("FAIL b2b_stalls: got %0d stall cycles required 0", totw); end
        idle(3);
        total++;
        if (frames_out - f0 != 4) begin bad++; $display("FAIL b2b_frames: got %0d required 4", frames_out - f0); end
    endtask

    task automatic test_same_edge();
        int w;
        logic [W-1:0] d;
        logic [BS-1:0][W-1:0] fb;
        data_out_ready = 1'b0;
        for (int i = 0; i < BS; i++) send_beat(W'($urandom), 1'b0, w);
        for (int i = 0; i < BS; i++) begin
            d = W'($urandom);
            fb[i] = d;
            if (i == BS - 1) data_out_ready = 1'b1;
            send_beat(d, 1'b0, w);
        end
        data_in_valid = 1'b0;
        total += 4;
        if (data_out_valid !== 1'b1) begin bad++; $display("FAIL same_edge_valid: got %b required 1", data_out_valid); end
        if (data_in_ready !== 1'b1) begin bad++; $display("FAIL same_edge_no_hold: in_ready=%b required 1", data_in_ready); end
        if (data_out !== fb) begin bad++; $display("FAIL same_edge_frame: got %h required %h", data_out, fb); end
        if (data_out_count !== CW'(BS)) begin bad++; $display("FAIL same_edge_count: got %0d required %0d", data_out_count, BS); end
        idle(2);
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            data_in        = W'($urandom);
            data_in_valid  = ($urandom_range(0, 3) != 0);
            data_in_last   = ($urandom_range(0, 7) == 0);
            data_out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        data_in_valid  = 1'b0;
        data_in_last   = 1'b0;
        data_out_ready = 1'b1;
        idle(5);
        total += 2;
        if (exp_dat_q.size() != 0) begin bad++; $display("FAIL random_pending_frames: got %0d required 0", exp_dat_q.size()); end
        if (data_out_valid !== 1'b0) begin bad++; $display("FAIL random_final_valid: got %b required 0", data_out_valid); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        data_in        = '0;
        data_in_valid  = 1'b0;
        data_in_last   = 1'b0;
        data_out_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_early_last();
        test_backpressure();
        test_back_to_back();
        test_same_edge();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
